surf4_pps_sync: RTL



---
 rtl/surf4_pps_sync.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/surf4_pps_sync.sv
// PPS qualification/lock with free-running fake PPS fallback, plus ext-trig
// debounce with running count. Single clock domain (wbc_clk).
module surf4_pps_sync #(
  parameter int CLK_HZ     = 33000000,
  parameter int TOL        = 3300,
  parameter int LOCK_COUNT = 2,
  parameter int DEBOUNCE   = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        pps_i,
  input  logic        ext_trig_i,
  input  logic        force_internal_i,
  output logic        pps_o,
  output logic        pps_locked_o,
  output logic [31:0] pps_period_o,
  output logic        ext_trig_o,
  output logic [15:0] ext_trig_count_o
);

  localparam logic [31:0] WIN_LO = 32'(CLK_HZ - TOL);
  localparam logic [31:0] WIN_HI = 32'(CLK_HZ + TOL);
  localparam logic [31:0] TC_INT = 32'(CLK_HZ - 1);
  localparam logic [31:0] TC_EXT = 32'(CLK_HZ + TOL - 1);
  localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
  localparam int DEB_W  = $clog2(DEBOUNCE + 1);
  localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEBOUNCE);

  typedef enum logic {ST_INT, ST_EXT} state_t;

  state_t            state;
  logic              pps_p0, pps_p1, pps_p2;
  logic              ext_edge;
  logic [31:0]       ext_cnt;
  logic [31:0]       int_cnt;
  logic [GOOD_W-1:0] good;
  logic [31:0]       period;
  logic              valid;
  logic              lock_now;

  logic              trig_p0, trig_p1, trig_p2;
  logic [DEB_W-1:0]  stab;
  logic [DEB_W-1:0]  stab_nxt;
  logic              armed;
  logic [15:0]       trig_cnt;

  assign period   = (ext_cnt == '1) ? '1 : ext_cnt + 32'd1;
  assign valid    = ext_edge && (period >= WIN_LO) && (period <= WIN_HI);
  assign lock_now = valid && ((int'(good) + 1) >= LOCK_COUNT);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pps_p0       <= 1'b0;
      pps_p1       <= 1'b0;
      pps_p2       <= 1'b0;
      ext_edge     <= 1'b0;
      ext_cnt      <= '0;
      int_cnt      <= '0;
      good         <= '0;
      state        <= ST_INT;
      pps_o        <= 1'b0;
      pps_locked_o <= 1'b0;
      pps_period_o <= '0;
    end else begin
      // sync stage: two flops for metastability, third for edge detect
      pps_p0   <= pps_i;
      pps_p1   <= pps_p0;
      pps_p2   <= pps_p1;
      ext_edge <= pps_p1 & ~pps_p2;

      // measure stage: period counter and lock FSM
      pps_o <= 1'b0;
      if (ext_edge) begin
        ext_cnt      <= '0;
        pps_period_o <= period;
      end else if (ext_cnt != '1) begin
        ext_cnt <= ext_cnt + 32'd1;
      end

      if (force_internal_i || state == ST_INT) begin
        if (!force_internal_i && lock_now) begin
          state        <= ST_EXT;
          pps_locked_o <= 1'b1;
          pps_o        <= 1'b1;
          int_cnt      <= '0;
          good         <= '0;
        end else begin
          state        <= ST_INT;
          pps_locked_o <= 1'b0;
          // >= so a count left past TC by a forced exit from EXTERNAL still wraps
          if (int_cnt >= TC_INT) begin
            pps_o   <= 1'b1;
            int_cnt <= '0;
          end else begin
            int_cnt <= int_cnt + 32'd1;
          end
          if (force_internal_i || (ext_edge && !valid))
            good <= '0;
          else if (valid)
            good <= good + GOOD_W'(1);
        end
      end else begin
        if (valid) begin
          pps_o   <= 1'b1;
          int_cnt <= '0;
        end else if (ext_edge) begin
          state        <= ST_INT;
          pps_locked_o <= 1'b0;
          good         <= '0;
          int_cnt      <= int_cnt + 32'd1;
        end else if (int_cnt >= TC_EXT) begin
          state        <= ST_INT;
          pps_locked_o <= 1'b0;
          good         <= '0;
          pps_o        <= 1'b1;
          int_cnt      <= '0;
        end else begin
          int_cnt <= int_cnt + 32'd1;
        end
      end
    end
  end

  assign stab_nxt = (trig_p1 != trig_p2) ? '0 :
                    (stab == DEB_MAX)    ? DEB_MAX : stab + DEB_W'(1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      trig_p0    <= 1'b0;
      trig_p1    <= 1'b0;
      trig_p2    <= 1'b0;
      stab       <= '0;
      armed      <= 1'b1;
      ext_trig_o <= 1'b0;
      trig_cnt   <= '0;
    end else begin
      // sync stage
      trig_p0 <= ext_trig_i;
      trig_p1 <= trig_p0;
      trig_p2 <= trig_p1;

      // debounce stage
      stab       <= stab_nxt;
      ext_trig_o <= 1'b0;
      if (trig_p1 && armed && stab_nxt == DEB_MAX) begin
        ext_trig_o <= 1'b1;
        trig_cnt   <= trig_cnt + 16'd1;
        armed      <= 1'b0;
      end else if (!trig_p1 && stab_nxt == DEB_MAX) begin
        armed <= 1'b1;
      end
    end
  end

  assign ext_trig_count_o = trig_cnt;

endmodule
